// File: rtl/wb_regfile_pkg.sv
// Shared register-file definitions: bus widths, register count,
// NOP/zero constants and the MEM/WB bundle carried into writeback.
package wb_regfile_pkg;

  localparam int RegAddrW = 5;
  localparam int RegW     = 32;
  localparam int RegNum   = 32;

  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [RegW-1:0]     reg_t;

  localparam reg_addr_t NOPRegAddr   = '0;
  localparam reg_t      ZeroWord     = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      RstEnable    = 1'b1;

  typedef struct packed {
    reg_addr_t wd;
    logic      wreg;
    reg_t      wdata;
  } mem_wb_t;

  localparam mem_wb_t WbNop = '{
    wd:    NOPRegAddr,
    wreg:  WriteDisable,
    wdata: ZeroWord
  };

endpackage

// File: rtl/wb_regfile_regfile.sv
// 32x32 register file: one write port, two bypassed read ports.
// Ports: clk/rst, we_i/waddr_i/wdata_i write, reN_i/raddrN_i -> rdataN_o.
module wb_regfile_regfile
  import wb_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  reg_t      wdata_i,
  input  logic      re1_i,
  input  reg_addr_t raddr1_i,
  output reg_t      rdata1_o,
  input  logic      re2_i,
  input  reg_addr_t raddr2_i,
  output reg_t      rdata2_o
);

  reg_t mem_q [RegNum];

  logic wr_en;
  assign wr_en = (we_i == WriteEnable) && (waddr_i != NOPRegAddr);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) begin
        mem_q[i] <= ZeroWord;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Bypass wins over storage so a read in the commit cycle
  // already sees the value being written.
  always_comb begin
    rdata1_o = ZeroWord;
    if (rst == RstEnable) begin
      rdata1_o = ZeroWord;
    end else if (re1_i != ReadEnable || raddr1_i == NOPRegAddr) begin
      rdata1_o = ZeroWord;
    end else if (we_i == WriteEnable && raddr1_i == waddr_i) begin
      rdata1_o = wdata_i;
    end else begin
      rdata1_o = mem_q[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = ZeroWord;
    if (rst == RstEnable) begin
      rdata2_o = ZeroWord;
    end else if (re2_i != ReadEnable || raddr2_i == NOPRegAddr) begin
      rdata2_o = ZeroWord;
    end else if (we_i == WriteEnable && raddr2_i == waddr_i) begin
      rdata2_o = wdata_i;
    end else begin
      rdata2_o = mem_q[raddr2_i];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB pipeline register feeding a bypassed 32x32 register file.
// Ports: clk/rst, stall/flush, mem inputs (wd/wreg/wdata_i), two read
// ports (reN/raddrN/rdataN) and registered WB outputs (wb_*_o).
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      stall,
  input  logic      flush,
  input  reg_addr_t wd_i,
  input  logic      wreg_i,
  input  reg_t      wdata_i,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_t      rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_t      rdata2,
  output reg_addr_t wb_wd_o,
  output logic      wb_wreg_o,
  output reg_t      wb_wdata_o
);

  mem_wb_t wb_q;
  mem_wb_t wb_d;

  // Flush outranks stall; a held entry keeps rewriting the
  // same value, which is harmless.
  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d = WbNop;
    end else if (!stall) begin
      wb_d = '{wd: wd_i, wreg: wreg_i, wdata: wdata_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wb_q <= WbNop;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_wd_o    = wb_q.wd;
  assign wb_wreg_o  = wb_q.wreg;
  assign wb_wdata_o = wb_q.wdata;

  wb_regfile_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_q.wreg),
    .waddr_i  (wb_q.wd),
    .wdata_i  (wb_q.wdata),
    .re1_i    (re1),
    .raddr1_i (raddr1),
    .rdata1_o (rdata1),
    .re2_i    (re2),
    .raddr2_i (raddr2),
    .rdata2_o (rdata2)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, writes, r0,
// stall/flush, dual-read bypass and mid-run reset.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .re2        (re2),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .wb_wd_o    (wb_wd_o),
    .wb_wreg_o  (wb_wreg_o),
    .wb_wdata_o (wb_wdata_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic [4:0] a,
                     input logic w,
                     input logic [31:0] d);
    wd_i    = a;
    wreg_i  = w;
    wdata_i = d;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem(5'd0, 1'b0, 32'h0);
    re1 = 1'b1; raddr1 = 5'd5;
    re2 = 1'b1; raddr2 = 5'd5;

    edge1();
    edge1();
    #1;
    chk("rst_rd1", rdata1, 32'h0);
    chk("rst_rd2", rdata2, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_wreg", {31'h0, wb_wreg_o}, 32'h0);
    chk("rst_wd", {27'h0, wb_wd_o}, 32'h0);
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i);
      #1;
      chk($sformatf("rst_r%0d", i), rdata1, 32'h0);
    end

    // basic write r5
    mem(5'd5, 1'b1, 32'h12345678);
    raddr1 = 5'd5;
    edge1();
    mem(5'd0, 1'b0, 32'h0);
    #1;
    chk("w_wd", {27'h0, wb_wd_o}, 32'd5);
    chk("w_wreg", {31'h0, wb_wreg_o}, 32'd1);
    chk("w_wdata", wb_wdata_o, 32'h12345678);
    chk("w_bypass", rdata1, 32'h12345678);
    edge1();
    chk("w_wreg2", {31'h0, wb_wreg_o}, 32'd0);
    chk("w_store", rdata1, 32'h12345678);

    // register 0
    mem(5'd0, 1'b1, 32'hFFFFFFFF);
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    chk("r0_c0", rdata1, 32'h0);
    edge1();
    mem(5'd0, 1'b0, 32'h0);
    #1;
    chk("r0_c1", rdata1, 32'h0);
    chk("r0_c1b", rdata2, 32'h0);
    edge1();
    chk("r0_c2", rdata1, 32'h0);

    // stall / flush
    mem(5'd7, 1'b1, 32'hA5A5A5A5);
    edge1();
    stall = 1'b1;
    mem(5'd8, 1'b1, 32'h88888888);
    raddr1 = 5'd8; raddr2 = 5'd7;
    edge1();
    chk("st_wd", {27'h0, wb_wd_o}, 32'd7);
    chk("st_wdata", wb_wdata_o, 32'hA5A5A5A5);
    chk("st_r8", rdata1, 32'h0);
    chk("st_r7", rdata2, 32'hA5A5A5A5);
    flush = 1'b1;
    edge1();
    chk("fl_wreg", {31'h0, wb_wreg_o}, 32'd0);
    chk("fl_wd", {27'h0, wb_wd_o}, 32'd0);
    chk("fl_r8", rdata1, 32'h0);
    stall = 1'b0; flush = 1'b0;
    mem(5'd0, 1'b0, 32'h0);
    edge1();
    chk("fl_r8b", rdata1, 32'h0);
    chk("fl_r7", rdata2, 32'hA5A5A5A5);

    // dual read with bypass
    mem(5'd3, 1'b1, 32'h1);
    edge1();
    mem(5'd3, 1'b1, 32'h2);
    edge1();
    mem(5'd0, 1'b0, 32'h0);
    raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    chk("dr_rd1", rdata1, 32'h2);
    chk("dr_rd2", rdata2, 32'h2);
    re2 = 1'b0;
    #1;
    chk("dr_re2", rdata2, 32'h0);
    chk("dr_rd1b", rdata1, 32'h2);
    re2 = 1'b1;
    edge1();
    chk("dr_st1", rdata1, 32'h2);
    chk("dr_st2", rdata2, 32'h2);

    // reset while a write is pending
    mem(5'd9, 1'b1, 32'hDEADBEEF);
    raddr1 = 5'd9; raddr2 = 5'd5;
    edge1();
    mem(5'd0, 1'b0, 32'h0);
    #1;
    chk("mr_byp", rdata1, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("mr_rst_rd", rdata1, 32'h0);
    edge1();
    rst = 1'b0;
    #1;
    chk("mr_wreg", {31'h0, wb_wreg_o}, 32'd0);
    chk("mr_r9", rdata1, 32'h0);
    chk("mr_r5", rdata2, 32'h0);
    edge1();
    chk("mr_r9b", rdata1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
